// File: rtl/dpll_pkg.sv
// Shared definitions for the digital PLL: phase-detector status codes and the
// saturating clamp used by the loop filter.
package dpll_pkg;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEAD = 2'b01,
    ERR_LAG  = 2'b10,
    ERR_LOR  = 2'b11
  } err_t;

  // Wide enough for any ACC_W+2 filter intermediate up to ACC_W=62.
  localparam int CLAMP_W = 64;

  function automatic logic signed [CLAMP_W-1:0] clamp_s(
    input logic signed [CLAMP_W-1:0] x,
    input logic signed [CLAMP_W-1:0] lo,
    input logic signed [CLAMP_W-1:0] hi
  );
    if (x < lo) return lo;
    else if (x > hi) return hi;
    else return x;
  endfunction

  function automatic logic clamp_hit(
    input logic signed [CLAMP_W-1:0] x,
    input logic signed [CLAMP_W-1:0] lo,
    input logic signed [CLAMP_W-1:0] hi
  );
    return (x < lo) || (x > hi);
  endfunction

endpackage

// File: rtl/ref_edge_sync.sv
// Brings the comparator output into clk, flags one-cycle rising edges and
// declares loss of reference after TIMEOUT enabled cycles without an edge.
module ref_edge_sync #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic nrst,
  input  logic enable,
  input  logic clr,
  input  logic ref_in,
  output logic ref_edge,
  output logic lor
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    sync_reg;
  logic          ref_edge_reg;
  logic [TW-1:0] to_cnt_reg;

  always_ff @(posedge clk) begin
    if (nrst) begin
      sync_reg     <= '0;
      ref_edge_reg <= 1'b0;
      to_cnt_reg   <= '0;
    end else begin
      sync_reg     <= {sync_reg[1:0], ref_in};
      ref_edge_reg <= sync_reg[1] & ~sync_reg[2];
      // Edges seen while disabled are ignored, so they do not rearm the timer.
      if (clr || (ref_edge_reg && enable))
        to_cnt_reg <= '0;
      else if (enable && (to_cnt_reg != TW'(TIMEOUT)))
        to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign ref_edge = ref_edge_reg;
  assign lor      = (to_cnt_reg == TW'(TIMEOUT));

endmodule

// File: rtl/dpll_nco.sv
// All-digital PLL: phase-accumulator NCO steered by a sampled phase detector
// and a shift-coefficient PI filter, with clamping, lock and timeout tracking.
module dpll_nco
  import dpll_pkg::*;
#(
  parameter int               ACC_W        = 32,
  parameter logic [ACC_W-1:0] FREQ_DEFAULT = 32'h0018_F81F,
  parameter logic [ACC_W-1:0] FREQ_MIN     = 32'h0000_4000,
  parameter logic [ACC_W-1:0] FREQ_MAX     = 32'h0100_0000,
  parameter logic [ACC_W-1:0] LOCK_TOL     = 32'h0010_0000,
  parameter int               LOCK_N       = 8,
  parameter int               TIMEOUT      = 65535
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             load,
  input  logic [ACC_W-1:0] freq_init,
  input  logic [4:0]       kp_shift,
  input  logic [4:0]       ki_shift,
  output logic [ACC_W-1:0] freq_word,
  output logic [ACC_W-1:0] phase,
  output logic             nco_out,
  output logic             lock,
  output logic [1:0]       err,
  output logic             clamped
);

  localparam int W2  = ACC_W + 2;
  localparam int LCW = $clog2(LOCK_N + 1);
  localparam logic signed [CLAMP_W-1:0] LO_W = CLAMP_W'(FREQ_MIN);
  localparam logic signed [CLAMP_W-1:0] HI_W = CLAMP_W'(FREQ_MAX);

  logic             ref_edge, lor;
  logic [ACC_W-1:0] phase_reg, freq_reg, integ_reg, pe_reg;
  logic             pend_reg, lock_reg, clamped_reg;
  logic [LCW-1:0]   lock_cnt_reg;
  err_t             err_reg;

  logic signed [W2-1:0] pe_w, pe_abs, integ_raw, freq_raw;
  logic [ACC_W-1:0]     integ_n, freq_n;
  logic                 integ_hit, freq_hit, in_win;
  err_t                 err_pd;

  ref_edge_sync #(.TIMEOUT(TIMEOUT)) u_sync (
    .clk      (clk),
    .nrst     (nrst),
    .enable   (enable),
    .clr      (load),
    .ref_in   (ref_in),
    .ref_edge (ref_edge),
    .lor      (lor)
  );

  always_comb begin
    pe_w      = {{2{pe_reg[ACC_W-1]}}, pe_reg};
    integ_raw = $signed({2'b00, integ_reg}) - (pe_w >>> ki_shift);
    integ_n   = ACC_W'(clamp_s(CLAMP_W'(integ_raw), LO_W, HI_W));
    integ_hit = clamp_hit(CLAMP_W'(integ_raw), LO_W, HI_W);
    freq_raw  = $signed({2'b00, integ_n}) - (pe_w >>> kp_shift);
    freq_n    = ACC_W'(clamp_s(CLAMP_W'(freq_raw), LO_W, HI_W));
    freq_hit  = clamp_hit(CLAMP_W'(freq_raw), LO_W, HI_W);
    // Negating at W2 bits keeps the most-negative pe positive, so it falls outside the window.
    pe_abs    = pe_w[W2-1] ? -pe_w : pe_w;
    in_win    = pe_abs < $signed({2'b00, LOCK_TOL});
    if (pe_reg[ACC_W-1])
      err_pd = ERR_LAG;
    else if (pe_reg == '0)
      err_pd = ERR_NONE;
    else
      err_pd = ERR_LEAD;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      phase_reg    <= '0;
      integ_reg    <= FREQ_DEFAULT;
      freq_reg     <= FREQ_DEFAULT;
      pe_reg       <= '0;
      pend_reg     <= 1'b0;
      lock_reg     <= 1'b0;
      lock_cnt_reg <= '0;
      err_reg      <= ERR_NONE;
      clamped_reg  <= 1'b0;
    end else if (load) begin
      phase_reg    <= '0;
      integ_reg    <= freq_init;
      freq_reg     <= freq_init;
      pend_reg     <= 1'b0;
      lock_reg     <= 1'b0;
      lock_cnt_reg <= '0;
      err_reg      <= ERR_NONE;
    end else begin
      if (enable) phase_reg <= phase_reg + freq_reg;
      pend_reg <= ref_edge & enable;
      if (ref_edge && enable) pe_reg <= phase_reg;

      if (pend_reg && enable) begin
        integ_reg   <= integ_n;
        freq_reg    <= freq_n;
        clamped_reg <= integ_hit | freq_hit;
        err_reg     <= err_pd;
        if (in_win) begin
          if (lock_cnt_reg != LCW'(LOCK_N)) lock_cnt_reg <= lock_cnt_reg + 1'b1;
          lock_reg <= (lock_cnt_reg >= LCW'(LOCK_N - 1));
        end else begin
          lock_cnt_reg <= '0;
          lock_reg     <= 1'b0;
        end
      end

      if (!enable || lor) begin
        lock_reg     <= 1'b0;
        lock_cnt_reg <= '0;
      end
      if (lor) err_reg <= ERR_LOR;
    end
  end

  assign freq_word = freq_reg;
  assign phase     = phase_reg;
  assign nco_out   = phase_reg[ACC_W-1];
  assign lock      = lock_reg;
  assign err       = err_reg;
  assign clamped   = clamped_reg;

endmodule

// File: tb/tb_dpll_nco.sv
// Directed and randomized checks of dpll_nco against a cycle-level behavioural
// model built from the PLL's arithmetic rules.
module tb_dpll_nco;

  localparam longint FMIN    = 64'h0000_4000;
  localparam longint FMAX    = 64'h0100_0000;
  localparam longint TOL     = 64'h0010_0000;
  localparam int     LOCK_N  = 8;
  localparam int     TIMEOUT = 65535;

  logic        clk = 1'b0;
  logic        nrst, enable, ref_in, load;
  logic [31:0] freq_init;
  logic [4:0]  kp_shift, ki_shift;
  logic [31:0] freq_word, phase;
  logic        nco_out, lock, clamped;
  logic [1:0]  err;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_phase, m_freq, m_integ, m_pe;
  logic        m_pend, m_lock, m_clamped;
  logic [1:0]  m_err;
  int          m_lcnt, m_to;
  logic [3:0]  hist;   // ref_in samples from the last four clocks, newest in bit 0

  dpll_nco dut (
    .clk       (clk),
    .nrst      (nrst),
    .enable    (enable),
    .ref_in    (ref_in),
    .load      (load),
    .freq_init (freq_init),
    .kp_shift  (kp_shift),
    .ki_shift  (ki_shift),
    .freq_word (freq_word),
    .phase     (phase),
    .nco_out   (nco_out),
    .lock      (lock),
    .err       (err),
    .clamped   (clamped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic filter_update();
    longint pe, a, b;
    logic h1, h2;
    pe = longint'($signed(m_pe));
    a  = longint'(m_integ) - (pe >>> ki_shift);
    h1 = (a < FMIN) || (a > FMAX);
    if (a < FMIN) a = FMIN; else if (a > FMAX) a = FMAX;
    b  = a - (pe >>> kp_shift);
    h2 = (b < FMIN) || (b > FMAX);
    if (b < FMIN) b = FMIN; else if (b > FMAX) b = FMAX;
    m_integ   = a[31:0];
    m_freq    = b[31:0];
    m_clamped = h1 | h2;
    m_err     = (pe > 0) ? 2'b01 : (pe < 0) ? 2'b10 : 2'b00;
    if (pe > -TOL && pe < TOL) begin
      m_lcnt = (m_lcnt < LOCK_N) ? m_lcnt + 1 : LOCK_N;
      m_lock = (m_lcnt == LOCK_N);
    end else begin
      m_lcnt = 0;
      m_lock = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs presented at that edge.
  task automatic model_clock();
    logic        e, lor_now, pend_next;
    logic [31:0] ph_old, pe_next;
    if (nrst) begin
      m_phase = '0; m_integ = 32'h0018_F81F; m_freq = 32'h0018_F81F;
      m_pe = '0; m_pend = 1'b0; m_lock = 1'b0; m_lcnt = 0;
      m_err = 2'b00; m_clamped = 1'b0; m_to = 0; hist = '0;
    end else begin
      // A rise in ref_in becomes a visible edge two clocks after it is sampled.
      e       = hist[2] & ~hist[3];
      lor_now = (m_to == TIMEOUT);
      hist    = {hist[2:0], ref_in};
      if (load || (e && enable)) m_to = 0;
      else if (enable && m_to < TIMEOUT) m_to = m_to + 1;
      if (load) begin
        m_phase = '0; m_integ = freq_init; m_freq = freq_init;
        m_pend = 1'b0; m_lock = 1'b0; m_lcnt = 0; m_err = 2'b00;
      end else begin
        ph_old    = m_phase;
        pend_next = e && enable;
        pe_next   = pend_next ? ph_old : m_pe;
        if (enable) m_phase = ph_old + m_freq;
        if (m_pend && enable) filter_update();
        if (!enable || lor_now) begin
          m_lock = 1'b0;
          m_lcnt = 0;
        end
        if (lor_now) m_err = 2'b11;
        m_pend = pend_next;
        m_pe   = pe_next;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    chk("phase", phase, m_phase);
    chk("freq_word", freq_word, m_freq);
    chk("nco_out", nco_out, m_phase[31]);
    chk("lock", lock, m_lock);
    chk("err", err, m_err);
    chk("clamped", clamped, m_clamped);
  endtask

  initial begin
    nrst = 1'b1; enable = 1'b0; ref_in = 1'b0; load = 1'b0;
    freq_init = '0; kp_shift = 5'd4; ki_shift = 5'd4;
    repeat (2) step();
    chk("rst_freq", freq_word, 32'h0018_F81F);
    chk("rst_phase", phase, 32'h0);
    chk("rst_lock", lock, 1'b0);
    chk("rst_err", err, 2'b00);
    chk("rst_clamped", clamped, 1'b0);

    // Free-running NCO
    nrst = 1'b0; enable = 1'b1;
    repeat (3) step();
    chk("phase_inc", phase, 32'h0018_F81F * 3);

    // Load a new frequency word
    load = 1'b1; freq_init = 32'h0002_0000;
    step();
    load = 1'b0;
    chk("load_freq", freq_word, 32'h0002_0000);
    chk("load_phase", phase, 32'h0);

    // Edge landing in the load cycle is discarded
    ref_in = 1'b1;
    repeat (3) step();
    load = 1'b1;
    step();
    load = 1'b0; ref_in = 1'b0;
    repeat (6) step();
    chk("load_edge_drop", freq_word, 32'h0002_0000);

    // Reference exactly at the NCO rate, aligned so pe=0 on each edge
    kp_shift = 5'd31; ki_shift = 5'd31;
    load = 1'b1; freq_init = 32'h0100_0000;
    step();
    load = 1'b0;
    repeat (253) step();
    for (int k = 0; k < 8; k++) begin
      ref_in = 1'b1;
      repeat (8) step();
      ref_in = 1'b0;
      repeat (248) step();
    end
    chk("lock_acq", lock, 1'b1);
    chk("lock_err", err, 2'b00);

    // One edge a cycle late: pe is a full increment, outside the window
    step();
    ref_in = 1'b1;
    repeat (8) step();
    ref_in = 1'b0;
    repeat (10) step();
    chk("lock_drop", lock, 1'b0);
    chk("late_err", err, 2'b01);

    // Loss of reference
    repeat (TIMEOUT + 5) step();
    chk("lor_err", err, 2'b11);
    chk("lor_lock", lock, 1'b0);
    ref_in = 1'b1;
    repeat (6) step();
    chk("lor_resume", (err == 2'b11), 1'b0);

    // Strongly lagging edge with full integral gain drives both clamps
    ref_in = 1'b0; kp_shift = 5'd0; ki_shift = 5'd0;
    repeat (4) step();
    ref_in = 1'b1;
    step();
    load = 1'b1; freq_init = 32'h8000_0001;
    step();
    load = 1'b0;
    repeat (3) step();
    chk("clamp_freq", freq_word, 32'h0100_0000);
    chk("clamp_flag", clamped, 1'b1);
    chk("clamp_err", err, 2'b10);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) ref_in = ~ref_in;
      step();
    end

    // Loop frozen while disabled
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) ref_in = ~ref_in;
      step();
    end
    chk("disable_lock", lock, 1'b0);

    // Randomized operation including mid-pipeline resets and loads
    for (int i = 0; i < 2000; i++) begin
      nrst   = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 9) != 0);
      load   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) ref_in = ~ref_in;
      freq_init = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(32'h4000, 32'h0100_0000);
      if ($urandom_range(0, 31) == 0) begin
        kp_shift = 5'($urandom_range(0, 31));
        ki_shift = 5'($urandom_range(0, 31));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
